// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, ImmGen
// formats, datapath select encodings, FSM states and decoded opcode classes.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // ImmGen format select; ImmGen decodes the same values.
  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
    IMM_U = 3'b011, IMM_J = 3'b100, IMM_NONE = 3'b111
  } imm_t;

  typedef enum logic [1:0] {PC_PLUS4 = 2'b00, PC_ALU = 2'b01, PC_ALU_JALR = 2'b10} pc_src_t;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC = 2'b10} wb_sel_t;
  typedef enum logic [1:0] {A_RS1 = 2'b00, A_OLDPC = 2'b01, A_ZERO = 2'b10} alu_a_t;
  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_FUNCT = 2'b01, ALU_BRANCH = 2'b10} alu_op_t;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LUI, C_AUIPC, C_LOAD, C_STORE,
    C_BRANCH, C_JAL, C_JALR, C_FENCE, C_SYSTEM, C_ILLEGAL
  } cls_t;

  typedef struct packed {
    cls_t cls;
    imm_t imm;
  } dec_t;

  // Immediate format implied by an opcode class.
  function automatic imm_t imm_of(cls_t c);
    case (c)
      C_ALU_I, C_LOAD, C_JALR: return IMM_I;
      C_STORE:                 return IMM_S;
      C_BRANCH:                return IMM_B;
      C_LUI, C_AUIPC:          return IMM_U;
      C_JAL:                   return IMM_J;
      default:                 return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Single shared memory port between the control FSM (master) and memory.
interface rv_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, mem_we, mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr_sel, output mem_ready);
endinterface

// File: rtl/rv_ctrl_decode.sv
// Combinational opcode classifier; also feeds the ImmGen format select.
module rv_ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output dec_t       dec
);

  cls_t cls;

  // Map the major opcode onto a class; anything unrecognised is illegal.
  always_comb begin
    cls = C_ILLEGAL;
    case (opcode)
      OP_REG:    cls = C_ALU_R;
      OP_IMM:    cls = C_ALU_I;
      OP_LUI:    cls = C_LUI;
      OP_AUIPC:  cls = C_AUIPC;
      OP_LOAD:   cls = C_LOAD;
      OP_STORE:  cls = C_STORE;
      OP_BRANCH: cls = C_BRANCH;
      OP_JAL:    cls = C_JAL;
      OP_JALR:   cls = C_JALR;
      OP_FENCE:  cls = C_FENCE;
      OP_SYSTEM: cls = C_SYSTEM;
      default:   cls = C_ILLEGAL;
    endcase
  end

  assign dec.cls = cls;
  assign dec.imm = imm_of(cls);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, with a memory timeout and halt handling.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [6:0]                  opcode,
  input  logic [2:0]                  funct3,
  input  logic                        br_taken,
  rv_multicycle_ctrl_if.master        mem,
  output logic                        ir_we,
  output logic                        pc_we,
  output logic [1:0]                  pc_src,
  output logic [2:0]                  imm_type,
  output logic [1:0]                  alu_a_sel,
  output logic                        alu_b_sel,
  output logic [1:0]                  alu_op,
  output logic                        rf_we,
  output logic [1:0]                  wb_sel,
  output logic                        halted,
  output logic                        fault
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t         st, nxt;
  cls_t           cls_q;
  dec_t           dec;
  logic [CW-1:0]  cnt;
  logic           fault_q, fault_d, tmo_hit;
  logic           req, we, addr_sel, ir_we_c, pc_we_c, rf_we_c, b_c;
  pc_src_t        pc_src_c;
  imm_t           imm_c;
  alu_a_t         a_c;
  alu_op_t        op_c;
  wb_sel_t        wb_c;

  // funct3 is decoded by the ALU control, not by this FSM.
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  rv_ctrl_decode u_dec (.opcode(opcode), .dec(dec));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) st <= S_FETCH;
    else     st <= nxt;
  end

  // Timeout counter, latched opcode class and halt cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      cls_q   <= C_ILLEGAL;
      fault_q <= 1'b0;
    end else begin
      // Staying in FETCH/MEM means the request went unanswered this cycle.
      if (nxt == st && (st == S_FETCH || st == S_MEM)) cnt <= cnt + CW'(1);
      else                                             cnt <= '0;
      if (st == S_DECODE) cls_q <= dec.cls;
      if (nxt == S_HALT && st != S_HALT) fault_q <= fault_d;
    end
  end

  // Next-state and Moore datapath controls.
  always_comb begin
    nxt      = st;
    fault_d  = 1'b0;
    req      = 1'b0;
    we       = 1'b0;
    addr_sel = 1'b0;
    ir_we_c  = 1'b0;
    pc_we_c  = 1'b0;
    rf_we_c  = 1'b0;
    pc_src_c = PC_PLUS4;
    imm_c    = IMM_NONE;
    a_c      = A_RS1;
    b_c      = 1'b0;
    op_c     = ALU_ADD;
    wb_c     = WB_ALU;
    // This is the last cycle the request may stay unanswered.
    tmo_hit  = (cnt == CW'(TIMEOUT_CYCLES - 1));

    // ALU/ImmGen selects are held from EXEC through WB for the latched class.
    if (st == S_EXEC || st == S_MEM || st == S_WB) begin
      imm_c = imm_of(cls_q);
      case (cls_q)
        C_ALU_R:                 op_c = ALU_FUNCT;
        C_ALU_I:                 begin b_c = 1'b1; op_c = ALU_FUNCT; end
        C_LUI:                   begin a_c = A_ZERO;  b_c = 1'b1; end
        C_AUIPC, C_JAL:          begin a_c = A_OLDPC; b_c = 1'b1; end
        C_LOAD, C_STORE, C_JALR: b_c = 1'b1;
        C_BRANCH:                op_c = ALU_BRANCH;
        default: ;
      endcase
    end

    case (st)
      S_FETCH: begin
        req = 1'b1;
        if (mem.mem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          nxt     = S_DECODE;
        end else if (tmo_hit) begin
          nxt     = S_HALT;
          fault_d = 1'b1;
        end
      end
      S_DECODE: begin
        imm_c = dec.imm;
        case (dec.cls)
          C_FENCE:   nxt = S_FETCH;
          C_SYSTEM:  nxt = S_HALT;
          C_ILLEGAL: begin nxt = S_HALT; fault_d = 1'b1; end
          default:   nxt = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_LOAD, C_STORE: nxt = S_MEM;
          C_BRANCH: begin pc_we_c = br_taken; pc_src_c = PC_ALU; nxt = S_FETCH; end
          C_JAL:    begin pc_we_c = 1'b1; pc_src_c = PC_ALU;      nxt = S_WB; end
          C_JALR:   begin pc_we_c = 1'b1; pc_src_c = PC_ALU_JALR; nxt = S_WB; end
          default:  nxt = S_WB;
        endcase
      end
      S_MEM: begin
        req      = 1'b1;
        addr_sel = 1'b1;
        we       = (cls_q == C_STORE);
        if (mem.mem_ready) begin
          nxt = (cls_q == C_LOAD) ? S_WB : S_FETCH;
        end else if (tmo_hit) begin
          nxt     = S_HALT;
          fault_d = 1'b1;
        end
      end
      S_WB: begin
        rf_we_c = 1'b1;
        nxt     = S_FETCH;
        if (cls_q == C_LOAD)                        wb_c = WB_MEM;
        else if (cls_q == C_JAL || cls_q == C_JALR) wb_c = WB_PC;
      end
      default: ;
    endcase
  end

  // Strobes are suppressed in the reset cycle so nothing commits after rst.
  assign mem.mem_req      = req & ~rst;
  assign mem.mem_we       = we & ~rst;
  assign mem.mem_addr_sel = addr_sel;
  assign ir_we            = ir_we_c & ~rst;
  assign pc_we            = pc_we_c & ~rst;
  assign rf_we            = rf_we_c & ~rst;
  assign pc_src           = pc_src_c;
  assign imm_type         = imm_c;
  assign alu_a_sel        = a_c;
  assign alu_b_sel        = b_c;
  assign alu_op           = op_c;
  assign wb_sel           = wb_c;
  assign halted           = (st == S_HALT);
  assign fault            = fault_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: stimulus pushes the expected
// per-cycle control vector; a monitor compares it mid-cycle.
module tb_rv_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req, mem_we, addr_sel, ir_we, pc_we;
    logic [1:0] pc_src;
    logic [2:0] imm;
    logic [1:0] asel;
    logic       bsel;
    logic [1:0] aop;
    logic       rf_we;
    logic [1:0] wb;
    logic       halted, fault;
  } ov_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [6:0] pend_op = '0;
  logic [2:0] funct3 = '0;
  logic       br_taken = 1'b0;
  logic       ir_we, pc_we, alu_b_sel, rf_we, halted, fault;
  logic [1:0] pc_src, alu_a_sel, alu_op, wb_sel;
  logic [2:0] imm_type;

  rv_multicycle_ctrl_if mif();

  rv_multicycle_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
    .mem(mif), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .imm_type(imm_type),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op), .rf_we(rf_we),
    .wb_sel(wb_sel), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  ov_t   exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad = 0;

  function automatic ov_t idle();
    ov_t e = '0;
    e.imm = 3'b111;
    return e;
  endfunction

  function automatic ov_t fet(input logic rdy);
    ov_t e = idle();
    e.mem_req = 1'b1; e.ir_we = rdy; e.pc_we = rdy;
    return e;
  endfunction

  function automatic ov_t dec(input logic [2:0] imm);
    ov_t e = idle();
    e.imm = imm;
    return e;
  endfunction

  function automatic ov_t body(input logic [2:0] imm, input logic [1:0] a,
                               input logic b, input logic [1:0] o);
    ov_t e = idle();
    e.imm = imm; e.asel = a; e.bsel = b; e.aop = o;
    return e;
  endfunction

  function automatic ov_t hlt(input logic f);
    ov_t e = idle();
    e.halted = 1'b1; e.fault = f;
    return e;
  endfunction

  function automatic ov_t sample();
    ov_t a;
    a.mem_req = mif.mem_req; a.mem_we = mif.mem_we; a.addr_sel = mif.mem_addr_sel;
    a.ir_we = ir_we; a.pc_we = pc_we; a.pc_src = pc_src; a.imm = imm_type;
    a.asel = alu_a_sel; a.bsel = alu_b_sel; a.aop = alu_op; a.rf_we = rf_we;
    a.wb = wb_sel; a.halted = halted; a.fault = fault;
    return a;
  endfunction

  // One clock cycle of stimulus plus its expected control vector.
  task automatic step(input logic r, input logic rdy, input logic bt, input ov_t e, input string n);
    @(posedge clk); #1;
    rst = r; mif.mem_ready = rdy; br_taken = bt; opcode = pend_op;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic fetchw(input logic [6:0] op, input int nwait, input string n);
    pend_op = op;
    for (int i = 0; i < nwait; i++) step(1'b0, 1'b0, 1'b0, fet(1'b0), {n, ".Fw"});
    step(1'b0, 1'b1, 1'b0, fet(1'b1), {n, ".F"});
  endtask

  // F,D,E,W; mem_ready held high outside FETCH to show it is ignored there.
  task automatic ins_alu(input logic [6:0] op, input logic [2:0] imm, input logic [1:0] a,
                         input logic b, input logic [1:0] o, input string n);
    ov_t e;
    fetchw(op, 0, n);
    step(1'b0, 1'b1, 1'b0, dec(imm), {n, ".D"});
    step(1'b0, 1'b1, 1'b0, body(imm, a, b, o), {n, ".E"});
    e = body(imm, a, b, o); e.rf_we = 1'b1;
    step(1'b0, 1'b0, 1'b0, e, {n, ".W"});
  endtask

  task automatic ins_jump(input logic [6:0] op, input logic [2:0] imm, input logic [1:0] a,
                          input logic [1:0] src, input string n);
    ov_t e;
    fetchw(op, 0, n);
    step(1'b0, 1'b0, 1'b0, dec(imm), {n, ".D"});
    e = body(imm, a, 1'b1, 2'b00); e.pc_we = 1'b1; e.pc_src = src;
    step(1'b0, 1'b0, 1'b0, e, {n, ".E"});
    e = body(imm, a, 1'b1, 2'b00); e.rf_we = 1'b1; e.wb = 2'b10;
    step(1'b0, 1'b0, 1'b0, e, {n, ".W"});
  endtask

  task automatic ins_br(input logic bt, input string n);
    ov_t e;
    fetchw(7'h63, 0, n);
    step(1'b0, 1'b0, 1'b0, dec(3'b010), {n, ".D"});
    e = body(3'b010, 2'b00, 1'b0, 2'b10); e.pc_we = bt; e.pc_src = 2'b01;
    step(1'b0, 1'b0, bt, e, {n, ".E"});
  endtask

  task automatic ins_ld(input int nwait, input string n);
    ov_t e;
    fetchw(7'h03, 0, n);
    step(1'b0, 1'b0, 1'b0, dec(3'b000), {n, ".D"});
    step(1'b0, 1'b0, 1'b0, body(3'b000, 2'b00, 1'b1, 2'b00), {n, ".E"});
    e = body(3'b000, 2'b00, 1'b1, 2'b00); e.mem_req = 1'b1; e.addr_sel = 1'b1;
    for (int i = 0; i < nwait; i++) step(1'b0, 1'b0, 1'b0, e, {n, ".Mw"});
    step(1'b0, 1'b1, 1'b0, e, {n, ".M"});
    e = body(3'b000, 2'b00, 1'b1, 2'b00); e.rf_we = 1'b1; e.wb = 2'b01;
    step(1'b0, 1'b0, 1'b0, e, {n, ".W"});
  endtask

  task automatic ins_st(input string n);
    ov_t e;
    fetchw(7'h23, 0, n);
    step(1'b0, 1'b0, 1'b0, dec(3'b001), {n, ".D"});
    step(1'b0, 1'b0, 1'b0, body(3'b001, 2'b00, 1'b1, 2'b00), {n, ".E"});
    e = body(3'b001, 2'b00, 1'b1, 2'b00); e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = 1'b1;
    step(1'b0, 1'b1, 1'b0, e, {n, ".M"});
  endtask

  // Monitor: compare the DUT against the next expected vector mid-cycle.
  initial begin
    ov_t e, a;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = sample();
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s: got %h want %h", n, a, e);
        end
      end
    end
  end

  initial begin
    ov_t e;
    mif.mem_ready = 1'b0;
    // Reset: strobes held low even with mem_ready asserted.
    step(1'b1, 1'b0, 1'b0, idle(), "rst0");
    step(1'b1, 1'b1, 1'b0, idle(), "rst1");

    ins_alu(7'h13, 3'b000, 2'b00, 1'b1, 2'b01, "addi");
    ins_alu(7'h33, 3'b111, 2'b00, 1'b0, 2'b01, "rtype");
    ins_alu(7'h37, 3'b011, 2'b10, 1'b1, 2'b00, "lui");
    ins_alu(7'h17, 3'b011, 2'b01, 1'b1, 2'b00, "auipc");
    ins_ld(3, "lw");
    ins_st("sw");
    ins_br(1'b1, "beq_t");
    ins_br(1'b0, "beq_nt");
    ins_jump(7'h6F, 3'b100, 2'b01, 2'b01, "jal");
    ins_jump(7'h67, 3'b000, 2'b00, 2'b10, "jalr");
    fetchw(7'h0F, 0, "fence");
    step(1'b0, 1'b0, 1'b0, dec(3'b111), "fence.D");

    // Ready arrives in the 16th request cycle: normal completion.
    fetchw(7'h0F, 15, "late16");
    step(1'b0, 1'b0, 1'b0, dec(3'b111), "late16.D");

    // Reset while a load waits in MEM.
    fetchw(7'h03, 0, "rstmem");
    step(1'b0, 1'b0, 1'b0, dec(3'b000), "rstmem.D");
    step(1'b0, 1'b0, 1'b0, body(3'b000, 2'b00, 1'b1, 2'b00), "rstmem.E");
    e = body(3'b000, 2'b00, 1'b1, 2'b00); e.mem_req = 1'b1; e.addr_sel = 1'b1;
    step(1'b0, 1'b0, 1'b0, e, "rstmem.Mw");
    step(1'b0, 1'b0, 1'b0, e, "rstmem.Mw");
    e.mem_req = 1'b0;
    step(1'b1, 1'b1, 1'b0, e, "rstmem.rst");
    ins_alu(7'h13, 3'b000, 2'b00, 1'b1, 2'b01, "after_rst");

    // ECALL halts cleanly and ignores mem_ready.
    fetchw(7'h73, 0, "ecall");
    step(1'b0, 1'b0, 1'b0, dec(3'b111), "ecall.D");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, hlt(1'b0), "ecall.H");
    step(1'b1, 1'b0, 1'b0, hlt(1'b0), "ecall.rst");

    // Illegal opcode: fault halt, strobes low for 10 cycles.
    fetchw(7'h7F, 0, "illegal");
    step(1'b0, 1'b0, 1'b0, dec(3'b111), "illegal.D");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, hlt(1'b1), "illegal.H");
    step(1'b1, 1'b0, 1'b0, hlt(1'b1), "illegal.rst");

    // Fetch never answered: 16 request cycles, then fault halt.
    pend_op = 7'h13;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, fet(1'b0), "tmo.F");
    step(1'b0, 1'b1, 1'b0, hlt(1'b1), "tmo.H");
    step(1'b0, 1'b0, 1'b0, hlt(1'b1), "tmo.H");
    step(1'b1, 1'b0, 1'b0, hlt(1'b1), "tmo.rst");
    ins_alu(7'h13, 3'b000, 2'b00, 1'b1, 2'b01, "recover");

    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
